// File: rtl/rt_ctx_pkg.sv
// rt_ctx_pkg: shared FSM states and context-layout constants for the context-switch sequencer
package rt_ctx_pkg;
    typedef enum logic [2:0] {IDLE, SAVE, RESTORE_REQ, RESTORE_WAIT, DONE} state_t;
    localparam int NUM_SREG   = 32;
    localparam int NUM_VREG   = 16;
    localparam int CTX_WORDS  = 48;
    localparam int CTX_STRIDE = 64;
endpackage

// File: rtl/rt_ctx_addr_gen.sv
// rt_ctx_addr_gen: register index counter with scalar/vector decode and context-memory address
module rt_ctx_addr_gen
    import rt_ctx_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int TID_W    = 3,
    parameter int CTX_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [TID_W-1:0]  tid,
    output logic              last,
    output logic              is_vec,
    output logic [4:0]        sreg,
    output logic [3:0]        vreg,
    output logic [MEM_AW-1:0] addr
);
    logic [5:0] idx;
    always_ff @(posedge clk or posedge rst)
        if (rst) idx <= '0;
        else if (inc) idx <= last ? '0 : idx + 6'd1;
    assign last   = idx == 6'(CTX_WORDS - 1);
    assign is_vec = idx >= 6'(NUM_SREG);
    assign sreg   = idx[4:0];
    assign vreg   = idx[3:0];
    assign addr   = MEM_AW'(CTX_BASE + int'(tid) * CTX_STRIDE + int'(idx));
endmodule

// File: rtl/rt_ctx_switch_ctrl.sv
// rt_ctx_switch_ctrl: saves/restores 32 scalar + 16 vector registers of an RT core on a thread switch
// CTX_SWITCH_PERF_EN adds a saturating ctx_cycles switch-duration counter
module rt_ctx_switch_ctrl
    import rt_ctx_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int TID_W    = 3,
    parameter int CTX_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              context_switch,
    input  logic              end_program,
    input  logic [TID_W-1:0]  cur_tid,
    input  logic [TID_W-1:0]  next_tid,
    input  logic              next_valid,
    output logic              kernel_mode,
    output logic              switch_done,
    output logic              pd_scalar_wen,
    output logic [4:0]        pd_scalar_wb_address,
    output logic [31:0]       pd_scalar_wb_data,
    output logic              pd_vector_wen,
    output logic [3:0]        pd_vector_wb_address,
    output logic [127:0]      pd_vector_wb_data,
    output logic [4:0]        pd_scalar_read_address1,
    output logic [3:0]        pd_vector_read_address1,
    input  logic [31:0]       pd_scalar_read1,
    input  logic [127:0]      pd_vector_read1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [127:0]      mem_rdata
`ifdef CTX_SWITCH_PERF_EN
    ,
    output logic [15:0]       ctx_cycles
`endif
);
    state_t state, nxt;
    logic [TID_W-1:0]  cur_q, nxt_tid_q;
    logic              ign_q, is_vec, last, inc, wr;
    logic [4:0]        sreg;
    logic [3:0]        vreg;
    logic [MEM_AW-1:0] addr;

    rt_ctx_addr_gen #(.MEM_AW(MEM_AW), .TID_W(TID_W), .CTX_BASE(CTX_BASE)) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .tid    (state == SAVE ? cur_q : nxt_tid_q),
        .last   (last),
        .is_vec (is_vec),
        .sreg   (sreg),
        .vreg   (vreg),
        .addr   (addr)
    );

    // thread ids keep tracking the inputs while idle, so they freeze on the leaving edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cur_q     <= '0;
            nxt_tid_q <= '0;
            ign_q     <= 1'b0;
        end else begin
            state <= nxt;
            ign_q <= state == IDLE && end_program && !next_valid;
            if (state == IDLE) begin
                cur_q     <= cur_tid;
                nxt_tid_q <= next_tid;
            end
        end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:         nxt = end_program ? (next_valid ? RESTORE_REQ : IDLE) : context_switch ? SAVE : IDLE;
            SAVE:         nxt = mem_gnt && last ? (next_valid ? RESTORE_REQ : DONE) : SAVE;
            RESTORE_REQ:  nxt = mem_gnt ? RESTORE_WAIT : RESTORE_REQ;
            RESTORE_WAIT: nxt = mem_rvalid ? (last ? DONE : RESTORE_REQ) : RESTORE_WAIT;
            default:      nxt = IDLE;
        endcase
    end

    always_comb begin
        kernel_mode             = state != IDLE;
        switch_done             = state == DONE || ign_q;
        mem_req                 = state == SAVE || state == RESTORE_REQ;
        mem_we                  = state == SAVE;
        mem_addr                = mem_req ? addr : '0;
        mem_wdata               = !mem_we ? '0 : is_vec ? pd_vector_read1 : {96'b0, pd_scalar_read1};
        wr                      = state == RESTORE_WAIT && mem_rvalid;
        inc                     = (mem_we && mem_gnt) || wr;
        pd_scalar_read_address1 = mem_we && !is_vec ? sreg : '0;
        pd_vector_read_address1 = mem_we && is_vec ? vreg : '0;
        pd_scalar_wen           = wr && !is_vec;
        pd_vector_wen           = wr && is_vec;
        pd_scalar_wb_address    = pd_scalar_wen ? sreg : '0;
        pd_scalar_wb_data       = pd_scalar_wen ? mem_rdata[31:0] : '0;
        pd_vector_wb_address    = pd_vector_wen ? vreg : '0;
        pd_vector_wb_data       = pd_vector_wen ? mem_rdata : '0;
    end

`ifdef CTX_SWITCH_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) ctx_cycles <= '0;
        else if (state == IDLE && nxt != IDLE) ctx_cycles <= '0;
        else if (state != IDLE && ctx_cycles != 16'hFFFF) ctx_cycles <= ctx_cycles + 16'd1;
`endif
endmodule

// File: tb/tb_rt_ctx_switch_ctrl.sv
// tb_rt_ctx_switch_ctrl: randomized self-checking bench against a register-file/context-memory model
module tb_rt_ctx_switch_ctrl;
    localparam int MEM_AW = 16, TID_W = 3, CTX_BASE = 0;
    logic clk = 1'b0, rst = 1'b1;
    logic context_switch = 1'b0, end_program = 1'b0, next_valid = 1'b0;
    logic [TID_W-1:0] cur_tid = '0, next_tid = '0;
    logic kernel_mode, switch_done, pd_scalar_wen, pd_vector_wen, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [4:0] pd_scalar_wb_address, pd_scalar_read_address1;
    logic [3:0] pd_vector_wb_address, pd_vector_read_address1;
    logic [31:0] pd_scalar_wb_data, pd_scalar_read1;
    logic [127:0] pd_vector_wb_data, pd_vector_read1, mem_wdata, mem_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic stall = 1'b0;
    logic [31:0] srf [32];
    logic [127:0] vrf [16];
    logic [127:0] mem [int];
    logic [127:0] ref_mem [int];
    int n_chk = 0, n_pass = 0, writes = 0, reads = 0, stall_at = -1, stall_n = 0, last_cyc = 0;
    bit stall_rand = 1'b0;
    logic [MEM_AW-1:0] h_addr;
    logic [127:0] h_data;
`ifdef CTX_SWITCH_PERF_EN
    logic [15:0] ctx_cycles;
`endif

    rt_ctx_switch_ctrl #(.MEM_AW(MEM_AW), .TID_W(TID_W), .CTX_BASE(CTX_BASE)) dut (
        .clk(clk), .rst(rst), .context_switch(context_switch), .end_program(end_program),
        .cur_tid(cur_tid), .next_tid(next_tid), .next_valid(next_valid),
        .kernel_mode(kernel_mode), .switch_done(switch_done),
        .pd_scalar_wen(pd_scalar_wen), .pd_scalar_wb_address(pd_scalar_wb_address), .pd_scalar_wb_data(pd_scalar_wb_data),
        .pd_vector_wen(pd_vector_wen), .pd_vector_wb_address(pd_vector_wb_address), .pd_vector_wb_data(pd_vector_wb_data),
        .pd_scalar_read_address1(pd_scalar_read_address1), .pd_vector_read_address1(pd_vector_read_address1),
        .pd_scalar_read1(pd_scalar_read1), .pd_vector_read1(pd_vector_read1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CTX_SWITCH_PERF_EN
        , .ctx_cycles(ctx_cycles)
`endif
    );

    always #5 clk = ~clk;
    assign mem_gnt = mem_req && !stall;
    assign pd_scalar_read1 = srf[pd_scalar_read_address1];
    assign pd_vector_read1 = vrf[pd_vector_read_address1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory with zero-wait grant (unless stalled) and read data one cycle after grant; RF write port
    always @(posedge clk) begin
        if (rst) mem_rvalid <= 1'b0;
        else begin
            mem_rvalid <= mem_req && mem_gnt && !mem_we;
            if (mem_req && mem_gnt && mem_we) begin
                mem[int'(mem_addr)] = mem_wdata;
                writes++;
            end
            if (mem_req && mem_gnt && !mem_we) begin
                mem_rdata <= mem[int'(mem_addr)];
                reads++;
            end
            if (pd_scalar_wen) srf[pd_scalar_wb_address] = pd_scalar_wb_data;
            if (pd_vector_wen) vrf[pd_vector_wb_address] = pd_vector_wb_data;
        end
    end

    always @(negedge clk) begin
        if (stall_at >= 0 && mem_req && mem_we && writes == stall_at && stall_n < 10) begin
            if (stall_n == 0) begin
                h_addr = mem_addr;
                h_data = mem_wdata;
            end else begin
                check("hold_addr", 128'(mem_addr), 128'(h_addr));
                check("hold_data", mem_wdata, h_data);
            end
            stall = 1'b1;
            stall_n++;
        end else stall = stall_rand && ($urandom_range(3) == 0);
    end

    task automatic run(input bit cs, input bit ep, input bit nv, input int cur, input int nt, input bit zw, input int rst_at);
        logic [127:0] snap [48];
        logic [127:0] e;
        bit ign, do_save, do_rest, done;
        int n, km_bad;
        ign = ep && !nv;
        do_save = !ep && cs;
        do_rest = nv;
        for (int i = 0; i < 48; i++) snap[i] = i < 32 ? {96'b0, srf[i]} : vrf[i-32];
        writes = 0;
        reads = 0;
        km_bad = 0;
        @(negedge clk);
        context_switch = cs;
        end_program = ep;
        cur_tid = TID_W'(cur);
        next_tid = TID_W'(nt);
        next_valid = nv;
        @(posedge clk);
        #1;
        context_switch = 1'b0;
        end_program = 1'b0;
        cur_tid = TID_W'($urandom);
        next_tid = TID_W'($urandom);
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (rst_at >= 0 && reads == rst_at + 1) begin
                rst = 1'b1;
                #1;
                check("rst_km", 128'(kernel_mode), 128'(0));
                check("rst_outs", 128'({switch_done, mem_req, mem_we, mem_addr, pd_scalar_wen, pd_vector_wen}), 128'(0));
                @(negedge clk);
                rst = 1'b0;
                last_cyc = 0;
                return;
            end
            if (switch_done) done = 1'b1;
            else if (!kernel_mode) km_bad++;
        end
        check("done_seen", 128'(done), 128'(1));
        check("km_done", 128'(kernel_mode), 128'(!ign));
        if (zw) check("latency", 128'(n), 128'(ign ? 1 : (do_save ? 48 : 0) + (do_rest ? 96 : 0) + 1));
        @(negedge clk);
        check("km_idle", 128'(kernel_mode), 128'(0));
        check("done_pulse", 128'(switch_done), 128'(0));
        check("km_held", 128'(km_bad), 128'(0));
        check("writes", 128'(writes), 128'(do_save ? 48 : 0));
        check("reads", 128'(reads), 128'(do_rest ? 48 : 0));
`ifdef CTX_SWITCH_PERF_EN
        check("ctx_cycles", 128'(ctx_cycles), 128'(ign ? last_cyc : n));
`endif
        if (!ign) last_cyc = n;
        if (do_save)
            for (int i = 0; i < 48; i++) begin
                check("save_word", mem[CTX_BASE + cur * 64 + i], snap[i]);
                ref_mem[CTX_BASE + cur * 64 + i] = snap[i];
            end
        if (do_rest)
            for (int i = 0; i < 48; i++) begin
                e = ref_mem[CTX_BASE + nt * 64 + i];
                if (i < 32) check("restore_sreg", 128'(srf[i]), 128'(e[31:0]));
                else check("restore_vreg", vrf[i-32], e);
            end
    endtask

    initial begin
        logic [127:0] w;
        bit ep;
        for (int t = 0; t < 8; t++)
            for (int i = 0; i < 48; i++) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                mem[CTX_BASE + t * 64 + i] = w;
                ref_mem[CTX_BASE + t * 64 + i] = w;
            end
        for (int i = 0; i < 32; i++) srf[i] = $urandom;
        for (int i = 0; i < 16; i++) vrf[i] = {$urandom, $urandom, $urandom, $urandom};
        srf[5] = 32'hDEAD_BEEF;
        vrf[3] = {16{8'hA5}};
        repeat (3) @(negedge clk);
        check("reset_outs", 128'({kernel_mode, switch_done, mem_req, mem_we, mem_addr, pd_scalar_wen, pd_vector_wen}), 128'(0));
        rst = 1'b0;
        run(1, 0, 1, 2, 4, 1, -1);
        check("t1_r5_word", mem[2 * 64 + 5], {96'b0, 32'hDEAD_BEEF});
        check("t1_v3_word", mem[2 * 64 + 35], {16{8'hA5}});
        run(0, 1, 1, 0, 1, 1, -1);
        run(1, 1, 1, 6, 3, 1, -1);
        run(0, 1, 0, 0, 5, 1, -1);
        stall_at = 7;
        stall_n = 0;
        run(1, 0, 1, 5, 6, 0, -1);
        stall_at = -1;
        check("stall_cycles", 128'(stall_n), 128'(10));
        run(1, 0, 0, 7, 0, 1, -1);
        run(0, 1, 1, 0, 2, 1, 20);
        run(1, 0, 1, 3, 2, 1, -1);
        stall_rand = 1'b1;
        repeat (10) begin
            ep = 1'($urandom_range(1));
            run(ep ? 1'($urandom_range(1)) : 1'b1, ep, 1'($urandom_range(3) != 0),
                int'($urandom_range(7)), int'($urandom_range(7)), 1'b0, -1);
        end
        stall_rand = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rt_ctx_switch_ctrl.md
Name: rt_ctx_switch_ctrl

Overview:
Sequencer that performs a hardware thread context switch for one RT core.
- On a core's context-switch or end-of-program event, it holds the core in kernel mode.
- It saves all 32 scalar and 16 vector registers through the core's PD register-file ports to a context memory.
- It then restores the next thread's registers from that memory.
- Sits between the core, the thread scheduler and the context memory port.

Parameters:
MEM_AW, 16, context memory word-address width (128-bit words)
TID_W, 3, thread-id width
CTX_BASE, 0, context area base word address; thread t occupies words CTX_BASE + t*64 .. +47

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
context_switch  in  1  core requests switch (level; sampled in IDLE)
end_program  in  1  core thread finished (level; sampled in IDLE)
cur_tid  in  TID_W  thread currently on core
next_tid  in  TID_W  thread to load
next_valid  in  1  next_tid is valid
kernel_mode  out  1  core held/stalled, PD ports owned by this block
switch_done  out  1  one-cycle pulse at completion
pd_scalar_wen  out  1  scalar RF write enable
pd_scalar_wb_address  out  5  scalar write address
pd_scalar_wb_data  out  32  scalar write data
pd_vector_wen  out  1  vector RF write enable
pd_vector_wb_address  out  4  vector write address
pd_vector_wb_data  out  128  vector write data
pd_scalar_read_address1  out  5  scalar read address
pd_vector_read_address1  out  4  vector read address
pd_scalar_read1  in  32  scalar read data (combinational from address)
pd_vector_read1  in  128  vector read data (combinational from address)
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_AW  word address
mem_wdata  out  128  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  128  read data

Behaviour:
- Reset: state IDLE, idx=0; all outputs 0.
- Index idx 0..47: 0-31 are scalar r0-r31; 32-47 are vector v0-v15 (idx-32). Memory address = CTX_BASE + tid*64 + idx, truncated to MEM_AW.
- IDLE:
  - end_program=1 -> RESTORE_REQ (no save), kernel_mode=1. end_program wins if both inputs are high.
  - Else context_switch=1 -> SAVE.
  - Ignored if next_valid=0 and end_program=1: stay IDLE, pulse switch_done, no PD/mem activity.
- SAVE:
  - kernel_mode=1, mem_req=1, mem_we=1, mem_addr from latched cur_tid.
  - PD read address driven from idx.
  - mem_wdata = {96'b0, scalar} for scalar idx, vector data for vector idx.
  - On mem_gnt: idx++. At idx=47 with gnt, go to RESTORE_REQ with idx=0 if next_valid, else DONE.
- RESTORE_REQ: mem_req=1, mem_we=0, address from latched next_tid; on mem_gnt -> RESTORE_WAIT.
- RESTORE_WAIT:
  - mem_req=0.
  - On mem_rvalid: write mem_rdata[31:0] to the scalar RF (idx<32) or mem_rdata to the vector RF, one-cycle wen in the same cycle.
  - idx++; go to RESTORE_REQ, or DONE after idx=47.
  - At most one read outstanding.
- DONE: switch_done=1 for one cycle, kernel_mode=1 in this cycle, then IDLE with kernel_mode=0.
- cur_tid/next_tid are latched on leaving IDLE; later changes are ignored.
- mem_rvalid outside RESTORE_WAIT is ignored.
- Latency with zero-wait memory and rvalid 1 cycle after gnt: save 48 cycles, restore 96 cycles, plus 1 DONE cycle.
- rst mid-operation: immediate return to IDLE; partial memory/RF contents are undefined; kernel_mode drops.

Optional Feature:
CTX_SWITCH_PERF_EN
- Defined: adds output ctx_cycles[15:0]. Counts cycles from leaving IDLE to DONE, saturating at 16'hFFFF; the value is held until the next switch starts; reset 0.
- Undefined: no port, no counter.

Decomposition:
- Package rt_ctx_pkg: state enum (IDLE, SAVE, RESTORE_REQ, RESTORE_WAIT, DONE), constants NUM_SREG=32, NUM_VREG=16, CTX_WORDS=48, CTX_STRIDE=64.
- Sub-module rt_ctx_addr_gen: idx counter plus scalar/vector decode and memory address computation.

Test Plan:
1. Switch with preloaded scalar r5=32'hDEAD_BEEF, v3=all A5, cur_tid=2, next_tid=4, zero-wait memory -> memory word 2*64+5 = {96'b0,DEADBEEF} and word 2*64+35 = A5 pattern; thread 4 image is written to the RF; switch_done pulses after 145 cycles.
2. end_program with next_valid=1, next_tid=1 -> no mem writes; 48 reads from words 64..111; RF matches memory image.
3. context_switch and end_program in the same cycle -> restore-only path taken (no mem_we=1 observed).
4. mem_gnt held low for 10 cycles at idx=7 in SAVE -> address/data held stable; idx is not skipped; all 48 writes are correct.
5. rst asserted during RESTORE_WAIT at idx=20 -> next cycle all outputs 0, state IDLE; a new switch completes normally.
6. With CTX_SWITCH_PERF_EN, zero-wait memory, full switch -> ctx_cycles=145.
